// File: rtl/atanh_pwq.sv
// Piecewise-quadratic fixed-point atanh(x) in Q6.11. A single shared multiplier
// evaluates the Horner form over two cycles. The sign is stripped on entry and restored on exit.
module atanh_pwq #(
  parameter int QN = 6,
  parameter int QM = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [QN+QM:0]    operand,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [QN+QM:0]    result
);

  localparam int W = QN + QM + 1;
  localparam int PW = 2 * W + 1;

  // Interval thresholds on |x| and the saturation level, all in Q6.11
  localparam logic signed [W-1:0] TH_SAT = W'(1920);
  localparam logic signed [W-1:0] TH_I1  = W'(1024);
  localparam logic signed [W-1:0] TH_I2  = W'(1536);
  localparam logic signed [W-1:0] TH_I3  = W'(1792);
  localparam logic signed [W-1:0] Y_SAT  = W'(3584);

  typedef enum logic [1:0] {IDLE, EVAL1, EVAL2, OUTPUT} state_t;

  state_t state;
  logic sign;
  logic signed [W-1:0] a, p2, p1, p0, t;
  logic signed [W-1:0] x, x_abs;
  logic signed [W-1:0] sel_p2, sel_p1, sel_p0;
  logic signed [W-1:0] mul_a, addend, sum;
  logic signed [PW-1:0] prod;

  assign x     = $signed(operand);
  assign x_abs = x[W-1] ? -x : x;

  // Saturation is decided on the raw operand so abs never sees the most negative code
  always_comb begin
    sel_p2 = '0;
    sel_p1 = '0;
    sel_p0 = Y_SAT;
    if (x >= TH_SAT || x <= -TH_SAT) begin
      sel_p2 = '0;
      sel_p1 = '0;
      sel_p0 = Y_SAT;
    end else if (x_abs < TH_I1) begin
      sel_p2 = W'(631);
      sel_p1 = W'(1934);
      sel_p0 = W'(0);
    end else if (x_abs < TH_I2) begin
      sel_p2 = W'(3664);
      sel_p1 = W'(-1109);
      sel_p0 = W'(763);
    end else if (x_abs < TH_I3) begin
      sel_p2 = W'(15729);
      sel_p1 = W'(-19317);
      sel_p0 = W'(7633);
    end else begin
      sel_p2 = W'(16437);
      sel_p1 = W'(-17762);
      sel_p0 = W'(5681);
    end
  end

  assign mul_a  = (state == EVAL1) ? p2 : t;
  assign addend = (state == EVAL1) ? p1 : p0;
  assign prod   = $signed({{(W+1){mul_a[W-1]}}, mul_a}) * $signed({{(W+1){a[W-1]}}, a});
  assign sum    = W'(prod >>> QM) + addend;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      sign      <= 1'b0;
      a         <= '0;
      p2        <= '0;
      p1        <= '0;
      p0        <= '0;
      t         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign     <= x[W-1];
            a        <= x_abs;
            p2       <= sel_p2;
            p1       <= sel_p1;
            p0       <= sel_p0;
            in_ready <= 1'b0;
            state    <= EVAL1;
          end
        end
        EVAL1: begin
          t     <= sum;
          state <= EVAL2;
        end
        EVAL2: begin
          result    <= sign ? -sum : sum;
          out_valid <= 1'b1;
          state     <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_atanh_pwq.sv
// Directed checks for atanh_pwq: reset, per-interval results, boundaries, saturation,
// abort by reset, and output backpressure.
module tb_atanh_pwq;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] operand;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] result;

  int vectors;
  int miscompares;

  atanh_pwq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operand   (operand),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkValue(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Offers x at a falling edge and returns just after the accepting rising edge
  task automatic applyStimulus(input int x);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    operand  = 18'(x);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkValue("accept_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges from accept (inclusive) to out_valid, then checks the signed result
  task automatic checkOutput(input string tag, input int expected);
    int edges;
    edges = 1;
    while (!out_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checkValue({tag, "_latency"}, edges, 3);
    checkValue(tag, int'($signed(result)), expected);
    if (out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int seen;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    in_valid    = 1'b0;
    operand     = '0;
    out_ready   = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    checkValue("reset_in_ready", int'(in_ready), 1);
    checkValue("reset_out_valid", int'(out_valid), 0);
    checkValue("reset_result", int'($signed(result)), 0);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(512);     checkOutput("x_512", 522);
    applyStimulus(-512);    checkOutput("x_m512", -522);
    applyStimulus(0);       checkOutput("x_0", 0);
    applyStimulus(1024);    checkOutput("x_1024", 1124);
    applyStimulus(1023);    checkOutput("x_1023", 1123);
    applyStimulus(-1024);   checkOutput("x_m1024", -1124);
    applyStimulus(1535);    checkOutput("x_1535", 1989);
    applyStimulus(1536);    checkOutput("x_1536", 1992);
    applyStimulus(1792);    checkOutput("x_1792", 2723);
    applyStimulus(1919);    checkOutput("x_1919", 3468);
    applyStimulus(-1919);   checkOutput("x_m1919", -3468);
    applyStimulus(1920);    checkOutput("x_1920", 3584);
    applyStimulus(-1920);   checkOutput("x_m1920", -3584);
    applyStimulus(131071);  checkOutput("x_max", 3584);
    applyStimulus(-131072); checkOutput("x_min", -3584);

    // Abort in EVAL1: outputs clear at once, no stray result afterwards
    applyStimulus(512);
    checkValue("eval1_in_ready", int'(in_ready), 0);
    reset = 1'b1;
    #1;
    checkValue("abort_out_valid", int'(out_valid), 0);
    checkValue("abort_result", int'($signed(result)), 0);
    checkValue("abort_in_ready", int'(in_ready), 1);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checkValue("abort_no_stray", seen, 0);

    // Backpressure: result held, input side closed, in_valid pulses ignored
    out_ready = 1'b0;
    applyStimulus(1024);
    checkOutput("bp_result", 1124);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i % 2) == 0;
      operand  = 18'(512);
      @(posedge clk);
      #1;
      checkValue("bp_out_valid", int'(out_valid), 1);
      checkValue("bp_hold_result", int'($signed(result)), 1124);
      checkValue("bp_in_ready", int'(in_ready), 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkValue("bp_release_out_valid", int'(out_valid), 0);
    checkValue("bp_release_in_ready", int'(in_ready), 1);
    checkValue("bp_keep_result", int'($signed(result)), 1124);
    seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checkValue("bp_single_handshake", seen, 0);

    applyStimulus(-1536);   checkOutput("x_m1536", -1992);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
